// File: rtl/pwm_meter.sv
// PWM input meter: synchronises pwm_in, measures period and high time in clk cycles,
// derives integer duty percent with a 7-step restoring divider and flags stuck inputs.
module pwm_meter #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cyc,
    output logic [CNT_W-1:0] high_cyc,
    output logic [6:0]       duty_pct,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo,
    output logic             overrun
);

    localparam int               NUM_W  = CNT_W + 7;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    logic             sync1, pwm_s, pwm_d;
    logic             rise, fall, any_edge;
    logic [CNT_W-1:0] cnt;
    logic             armed, to_fire;
    state_t           state, state_next;
    logic             latch_hi, capture, accept, drop;
    logic [CNT_W-1:0] hi_lat, per_lat, hl;
    logic             div_busy, div_done, div_ge;
    logic [2:0]       div_idx;
    logic [NUM_W-1:0] div_rem, div_sub;
    logic [6:0]       div_quo;

    // NOTE: every register uses a synchronous reset and non-blocking assignments, so all
    // flops update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    assign rise     = pwm_s & ~pwm_d;
    assign fall     = ~pwm_s & pwm_d;
    assign any_edge = rise | fall;

    // cnt counts cycles since the last rise and parks at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (rise)           cnt <= CNT_W'(1);
        else if (cnt != TO_VAL)  cnt <= cnt + CNT_W'(1);
    end

    assign to_fire = (cnt == TO_VAL) && armed && !any_edge;

    always_ff @(posedge clk) begin
        if (rst)           armed <= 1'b1;
        else if (any_edge) armed <= 1'b1;
        else if (to_fire)  armed <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults first so no path through this block leaves a signal unassigned.
    always_comb begin
        state_next = state;
        latch_hi   = 1'b0;
        capture    = 1'b0;
        if (to_fire) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_next = HI;
                HI:   if (fall) begin
                          latch_hi   = 1'b1;
                          state_next = LO;
                      end
                LO:   if (rise) begin
                          capture    = 1'b1;
                          state_next = HI;
                      end
                default: state_next = IDLE;
            endcase
        end
    end

    assign accept = capture & ~div_busy;
    assign drop   = capture & div_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_lat  <= '0;
            per_lat <= '0;
            hl      <= '0;
        end else begin
            if (latch_hi) hi_lat <= cnt;
            if (accept) begin
                per_lat <= cnt;
                hl      <= hi_lat;
            end
        end
    end

    assign div_sub = NUM_W'(per_lat) << div_idx;
    assign div_ge  = (div_rem >= div_sub);

    // Quotient bit 6 first; the result is complete one cycle after index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_idx  <= '0;
            div_rem  <= '0;
            div_quo  <= '0;
        end else if (to_fire) begin
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else if (accept) begin
            div_busy <= 1'b1;
            div_done <= 1'b0;
            div_idx  <= 3'd6;
            div_rem  <= NUM_W'(hi_lat) * NUM_W'(100);
            div_quo  <= '0;
        end else if (div_busy) begin
            if (div_ge) div_rem <= div_rem - div_sub;
            div_quo[div_idx] <= div_ge;
            if (div_idx == 3'd0) begin
                div_busy <= 1'b0;
                div_done <= 1'b1;
            end else begin
                div_idx <= div_idx - 3'd1;
            end
        end else begin
            div_done <= 1'b0;
        end
    end

    // A timeout outranks a divider completion landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cyc <= '0;
            high_cyc   <= '0;
            duty_pct   <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (drop) overrun <= 1'b1;
            if (to_fire) begin
                period_cyc <= '0;
                high_cyc   <= '0;
                duty_pct   <= pwm_s ? 7'd100 : 7'd0;
                stuck_hi   <= pwm_s;
                stuck_lo   <= ~pwm_s;
                meas_valid <= 1'b1;
            end else begin
                if (div_done) begin
                    period_cyc <= per_lat;
                    high_cyc   <= hl;
                    duty_pct   <= div_quo;
                    meas_valid <= 1'b1;
                end
                if (any_edge) begin
                    stuck_hi <= 1'b0;
                    stuck_lo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: the driver predicts each result from the waveform it
// applies and queues it; a negedge monitor pops and compares on every meas_valid.
module tb_pwm_meter;

    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 3000;
    localparam int LAT     = 11;   // pin drive to meas_valid: 3 sync/detect + 8 divide

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] period_cyc, high_cyc;
    logic [6:0]       duty_pct;
    logic             meas_valid, stuck_hi, stuck_lo, overrun;

    pwm_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .period_cyc(period_cyc), .high_cyc(high_cyc), .duty_pct(duty_pct),
        .meas_valid(meas_valid), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int per;
        int hi;
        int duty;
        bit sh;
        bit sl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // model of the measurement FSM: 0 idle, 1 high, 2 low
    int   mstate;
    int   last_rise, last_fall, last_acc;
    bit   m_overrun;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int at, input int per, input int hi, input int duty,
                            input bit sh, input bit sl);
        exp_t e;
        e.at = at; e.per = per; e.hi = hi; e.duty = duty; e.sh = sh; e.sl = sl;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mstate    = 0;
        last_rise = 0;
        last_fall = 0;
        last_acc  = -100;
        m_overrun = 1'b0;
        sb.delete();
    endtask

    task automatic drive_rise();
        int n, per, hi;
        n = cyc;
        pwm_in = 1'b1;
        if (mstate == 2) begin
            per = n - last_rise;
            hi  = last_fall - last_rise;
            if (n - last_acc >= 8) begin
                push_exp(n + LAT, per, hi, (hi * 100) / per, 1'b0, 1'b0);
                last_acc = n;
            end else begin
                m_overrun = 1'b1;
            end
        end
        mstate    = 1;
        last_rise = n;
    endtask

    task automatic drive_fall();
        pwm_in = 1'b0;
        if (mstate == 1) begin
            mstate    = 2;
            last_fall = cyc;
        end
    endtask

    task automatic pulse(input int h, input int l);
        drive_rise();
        tick(h);
        drive_fall();
        tick(l);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period_cyc, 0);
        check({tag, "_high"},   high_cyc,   0);
        check({tag, "_duty"},   duty_pct,   0);
        check({tag, "_valid"},  meas_valid, 0);
        check({tag, "_sthi"},   stuck_hi,   0);
        check({tag, "_stlo"},   stuck_lo,   0);
        check({tag, "_ovr"},    overrun,    0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", meas_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("latency",  cyc,        mon_e.at);
                check("period",   period_cyc, mon_e.per);
                check("high",     high_cyc,   mon_e.hi);
                check("duty",     duty_pct,   mon_e.duty);
                check("stuck_hi", stuck_hi,   mon_e.sh);
                check("stuck_lo", stuck_lo,   mon_e.sl);
            end
        end
    end

    initial begin
        int n, m;
        rst    = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // 30 % duty, long period
        repeat (4) pulse(600, 1400);

        // truncation: 100/300 -> 33
        repeat (3) pulse(100, 200);

        // duty sweep 10..90 % on a 500-cycle period
        for (int d = 10; d <= 90; d += 10) begin
            repeat (3) pulse(5 * d, 500 - 5 * d);
        end

        // 100 %: held high until the timeout reports it, exactly once
        drive_rise();
        n = cyc;
        push_exp(n + 3 + TIMEOUT, 0, 0, 100, 1'b1, 1'b0);
        mstate = 0;
        tick(TIMEOUT + 300);
        check("held_stuck_hi", stuck_hi, 1);

        // the fall clears stuck_hi and re-arms; the counter is already parked at TIMEOUT
        drive_fall();
        m = cyc;
        push_exp(m + 4, 0, 0, 0, 1'b0, 1'b1);
        tick(10);
        check("fall_clears_hi", stuck_hi, 0);
        check("parked_stuck_lo", stuck_lo, 1);

        // too-short periods, then the shortest reportable one
        repeat (6) pulse(3, 3);
        repeat (4) pulse(4, 4);
        tick(20);
        check("overrun_set", overrun, 1);
        check("overrun_model", overrun, m_overrun);

        // reset while the FSM is in HI
        repeat (2) pulse(200, 200);
        drive_rise();
        tick(50);
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(1);
        check_all_zero("midrst");
        rst = 1'b0;
        model_reset();
        tick(20);
        repeat (2) pulse(200, 200);

        // rise in the same cycle the counter reaches TIMEOUT
        drive_rise();
        tick(500);
        drive_fall();
        tick(TIMEOUT - 500);
        drive_rise();
        tick(20);
        check("corner_stuck_lo", stuck_lo, 0);
        check("corner_stuck_hi", stuck_hi, 0);
        tick(100);
        drive_fall();
        tick(50);

        // random jitter
        for (int i = 0; i < 30; i++) begin
            pulse($urandom_range(1, 60), $urandom_range(1, 60));
        end
        drive_rise();
        tick(30);
        check("overrun_final", overrun, m_overrun);
        check("pending", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
